rr_stream_mux: RTL and testbench
================================

RR_STREAM_MUX -- requirements
Module: rr_stream_mux

Interface
REQ-001 Parameter NUM_CH, default 4, number of input channels (2..16).
REQ-002 Parameter DATA_W, default 8, data width per channel.
REQ-003 Parameter SEL_W, default $clog2(NUM_CH), width of select and channel-ID fields.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 mode  input  1  0 = fixed select (MODE_FIXED), 1 = round-robin (MODE_RR).
REQ-007 sel  input  SEL_W  channel selected in MODE_FIXED.
REQ-008 in_valid  input  NUM_CH  per-channel valid.
REQ-009 in_data  input  NUM_CH x DATA_W  per-channel data.
REQ-010 in_ready  output  NUM_CH  per-channel ready; combinational.
REQ-011 out_valid  output  1  output register holds a beat.
REQ-012 out_data  output  DATA_W  registered data.
REQ-013 out_ch  output  SEL_W  source channel of out_data.
REQ-014 out_ready  input  1  downstream ready.
REQ-015 beat_cnt  output  16  count of beats accepted into the output register.

Function
REQ-016 Transfer on input i occurs when in_valid[i] && in_ready[i]; output transfer when out_valid && out_ready.
REQ-017 load_en = !out_valid || out_ready; at most one in_ready bit high, and only when load_en is high.
REQ-018 MODE_FIXED: grant = sel if sel < NUM_CH and in_valid[sel]; otherwise no grant; sel >= NUM_CH never grants.
REQ-019 MODE_RR: grant = first i with in_valid[i], searching ptr, ptr+1, ... wrapping modulo NUM_CH.
REQ-020 ptr updates to (grant+1) mod NUM_CH only on an input transfer in MODE_RR; otherwise holds, including throughout MODE_FIXED.
REQ-021 On input transfer: out_data <= in_data[grant], out_ch <= grant, out_valid <= 1; latency exactly one cycle.
REQ-022 Output transfer with no input transfer in same cycle: out_valid <= 0; out_data/out_ch hold.
REQ-023 Simultaneous output and input transfer: register reloaded in the same edge, out_valid stays 1 (full throughput, one beat/cycle).
REQ-024 While out_valid && !out_ready: out_valid, out_data, out_ch stable; all in_ready low.
REQ-025 beat_cnt increments by 1 per input transfer; wraps 0xFFFF -> 0x0000.
REQ-026 mode/sel sampled every cycle; a change takes effect on the next grant decision, never disturbs a held output beat.
REQ-027 No grant possible: in_ready all low, register state unaffected except REQ-022.

Reset
REQ-028 rst_n low asynchronously forces out_valid=0, out_data=0, out_ch=0, ptr=0, beat_cnt=0.
REQ-029 During reset in_ready all low; a beat held at reset assertion is discarded.
REQ-030 First grant after rst_n deasserts is evaluated on the first rising edge with rst_n high.

Structure
REQ-031 Package mux_pkg holds defaults NUM_CH_DEF=4, DATA_W_DEF=8, and enum mode_e {MODE_FIXED, MODE_RR}.
REQ-032 Sub-module rr_arbiter (inputs req, ptr; outputs one-hot gnt, binary gnt_idx, gnt_vld) is instantiated once; ptr register stays in rr_stream_mux.
REQ-033 No latches; output register and counter are the only state besides ptr.

Verification
REQ-034 Fixed: mode=0, sel=2, in_valid=4'b1111, in_data[2]=8'hA5, out_ready=1 -> next cycle out_valid=1, out_data=A5, out_ch=2; in_ready=4'b0100.
REQ-035 RR fairness: mode=1, all valid, out_ready=1 for 8 cycles -> out_ch sequence 0,1,2,3,0,1,2,3; beat_cnt=8.
REQ-036 Backpressure: out_valid=1, out_ready=0 for 5 cycles with in_data changing -> out_data/out_ch constant, in_ready=0; release -> held beat leaves, next beat loads same edge.
REQ-037 Wrap/skip: ptr=3, in_valid=4'b0011 -> grant 0, then ptr=1 -> grant 1; sel=3 in fixed mode with NUM_CH=3 -> no grant ever.
REQ-038 Reset mid-transfer: rst_n low while out_valid=1 -> out_valid=0, beat_cnt=0 immediately without clock edge; after release RR restarts at channel 0.
REQ-039 Counter wrap: preload by 65535 transfers -> beat_cnt=FFFF, one more transfer -> 0000.

Source files
------------

// File: rtl/mux_pkg.sv
// Shared defaults and types for the round-robin stream multiplexer.
package mux_pkg;

   localparam int NUM_CH_DEF = 4;
   localparam int DATA_W_DEF = 8;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mode_e;

   // Adds an offset to a channel index and wraps it modulo n.
   // Both inputs are expected to be in the range 0..n-1.
   function automatic int wrap_add(input int base, input int off, input int n);
      int s;
      s = base + off;
      return (s >= n) ? (s - n) : s;
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority arbiter. The search starts at ptr and wraps around.
// The lowest offset from ptr that has a request wins.
// The winner is reported both one-hot and as a binary index.
module rr_arbiter
   import mux_pkg::*;
#(
   parameter int N     = NUM_CH_DEF,
   parameter int IDX_W = $clog2(N)
)
(
   input  logic [N-1:0]     req,
   input  logic [IDX_W-1:0] ptr,
   output logic [N-1:0]     gnt,
   output logic [IDX_W-1:0] gnt_idx,
   output logic             gnt_vld
);

   logic [IDX_W-1:0] pos;

   // Walk the offsets from farthest to nearest so the nearest requester is the last one written.
   always_comb begin
      gnt_idx = '0;
      gnt_vld = 1'b0;
      pos     = '0;
      for (int k = N - 1; k >= 0; k--) begin
         pos = IDX_W'(wrap_add(int'(ptr), k, N));
         if (req[pos]) begin
            gnt_vld = 1'b1;
            gnt_idx = pos;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N; gi++) begin : g_onehot
         assign gnt[gi] = gnt_vld && (gnt_idx == IDX_W'(gi));
      end
   endgenerate

endmodule

// File: rtl/rr_stream_mux.sv
// N-to-1 valid/ready stream multiplexer.
// The channel is chosen either by a fixed select or by round-robin arbitration.
// The output is held in a single register stage.
// That stage takes a new beat in the same cycle the held beat leaves, giving full throughput.
module rr_stream_mux
   import mux_pkg::*;
#(
   parameter int NUM_CH = NUM_CH_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int SEL_W  = $clog2(NUM_CH)
)
(
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           mode,
   input  logic [SEL_W-1:0]               sel,
   input  logic [NUM_CH-1:0]              in_valid,
   input  logic [NUM_CH-1:0][DATA_W-1:0]  in_data,
   output logic [NUM_CH-1:0]              in_ready,
   output logic                           out_valid,
   output logic [DATA_W-1:0]              out_data,
   output logic [SEL_W-1:0]               out_ch,
   input  logic                           out_ready,
   output logic [15:0]                    beat_cnt
);

   logic [SEL_W-1:0]  ptr_reg;
   logic [SEL_W-1:0]  ptr_next;
   logic              out_valid_reg;
   logic [DATA_W-1:0] out_data_reg;
   logic [SEL_W-1:0]  out_ch_reg;
   logic [15:0]       beat_cnt_reg;

   logic              rr_mode;
   logic              load_en;
   logic [NUM_CH-1:0] arb_gnt;
   logic [SEL_W-1:0]  arb_idx;
   logic              arb_vld;
   logic [NUM_CH-1:0] fix_gnt;
   logic              fix_vld;
   logic [SEL_W-1:0]  grant_idx;
   logic              in_xfer;

   rr_arbiter #(
      .N     (NUM_CH),
      .IDX_W (SEL_W)
   ) u_arb (
      .req     (in_valid),
      .ptr     (ptr_reg),
      .gnt     (arb_gnt),
      .gnt_idx (arb_idx),
      .gnt_vld (arb_vld)
   );

   assign rr_mode = (mode_e'(mode) == MODE_RR);

   // The register can accept a beat when it is empty or when its beat is leaving this cycle.
   assign load_en = !out_valid_reg || out_ready;

   // In fixed mode, an out-of-range select matches no channel, so it never grants.
   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_fixed
         assign fix_gnt[gi]  = in_valid[gi] && (sel == SEL_W'(gi));
         assign in_ready[gi] = rst_n && load_en && (rr_mode ? arb_gnt[gi] : fix_gnt[gi]);
      end
   endgenerate

   assign fix_vld   = |fix_gnt;
   assign grant_idx = rr_mode ? arb_idx : sel;
   assign in_xfer   = |(in_valid & in_ready);
   assign ptr_next  = (grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : grant_idx + SEL_W'(1);

   // Output register and beat counter: load on input transfer, empty on a lone output transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_reg <= 1'b0;
         out_data_reg  <= '0;
         out_ch_reg    <= '0;
         beat_cnt_reg  <= '0;
      end else if (in_xfer) begin
         out_valid_reg <= 1'b1;
         out_data_reg  <= in_data[grant_idx];
         out_ch_reg    <= grant_idx;
         beat_cnt_reg  <= beat_cnt_reg + 16'd1;
      end else if (out_valid_reg && out_ready) begin
         out_valid_reg <= 1'b0;
      end
   end

   // The round-robin pointer moves past the winner only on a round-robin transfer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_reg <= '0;
      end else if (in_xfer && rr_mode) begin
         ptr_reg <= ptr_next;
      end
   end

   // fix_vld summarises the fixed grant; it is kept for observability of the select path.
   logic unused_ok;
   assign unused_ok = fix_vld & arb_vld;

   assign out_valid = out_valid_reg;
   assign out_data  = out_data_reg;
   assign out_ch    = out_ch_reg;
   assign beat_cnt  = beat_cnt_reg;

endmodule

// File: tb/tb_rr_stream_mux.sv
// Scoreboard bench for rr_stream_mux.
// Stimulus pushes the hand-computed {channel, data} of each expected beat.
// A negedge monitor pops and compares on every output transfer.
module tb_rr_stream_mux;

   logic             clk = 1'b0;
   logic             rst_n;
   logic             mode;
   logic [1:0]       sel;
   logic [3:0]       in_valid;
   logic [3:0][7:0]  in_data;
   logic [3:0]       in_ready;
   logic             out_valid;
   logic [7:0]       out_data;
   logic [1:0]       out_ch;
   logic             out_ready;
   logic [15:0]      beat_cnt;

   logic             mode3;
   logic [1:0]       sel3;
   logic [2:0]       in_valid3;
   logic [2:0][7:0]  in_data3;
   logic [2:0]       in_ready3;
   logic             out_valid3;
   logic [7:0]       out_data3;
   logic [1:0]       out_ch3;
   logic             out_ready3;
   logic [15:0]      beat_cnt3;

   int               total = 0;
   int               bad   = 0;
   logic             mon_en = 1'b1;
   logic [15:0]      exp_q[$];

   always #5 clk = ~clk;

   rr_stream_mux #(.NUM_CH(4), .DATA_W(8)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_ready (out_ready),
      .beat_cnt  (beat_cnt)
   );

   rr_stream_mux #(.NUM_CH(3), .DATA_W(8)) dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode3),
      .sel       (sel3),
      .in_valid  (in_valid3),
      .in_data   (in_data3),
      .in_ready  (in_ready3),
      .out_valid (out_valid3),
      .out_data  (out_data3),
      .out_ch    (out_ch3),
      .out_ready (out_ready3),
      .beat_cnt  (beat_cnt3)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_beat(input logic [1:0] ch, input logic [7:0] data);
      exp_q.push_back({6'd0, ch, data});
   endtask

   // Monitor: one comparison pair per output transfer
   always @(negedge clk) begin
      if (mon_en && rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("beat_unexpected", 32'(out_ch), 32'hFFFF);
         end else begin
            logic [15:0] e;
            e = exp_q.pop_front();
            $display("beat ch=%0d data=%02h (want ch=%0d data=%02h)", out_ch, out_data, e[9:8], e[7:0]);
            check("beat_data", 32'(out_data), 32'(e[7:0]));
            check("beat_ch", 32'(out_ch), 32'(e[9:8]));
         end
      end
   end

   // Watchdog
   initial begin
      #1500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = 2'd0;
      in_valid  = 4'b1111;
      in_data   = '0;
      out_ready = 1'b1;
      mode3     = 1'b0;
      sel3      = 2'd3;
      in_valid3 = 3'b111;
      in_data3  = {8'h33, 8'h22, 8'h11};
      out_ready3 = 1'b1;

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_out_data", 32'(out_data), 0);
      check("rst_out_ch", 32'(out_ch), 0);
      check("rst_beat_cnt", 32'(beat_cnt), 0);
      check("rst_in_ready", 32'(in_ready), 0);
      in_valid = 4'b0000;
      rst_n    = 1'b1;
      step();

      // Fixed select, channel 2
      mode     = 1'b0;
      sel      = 2'd2;
      in_data  = {8'h44, 8'hA5, 8'h22, 8'h11};
      in_valid = 4'b1111;
      #1;
      check("fix_in_ready", 32'(in_ready), 32'b0100);
      expect_beat(2'd2, 8'hA5);
      step();
      in_valid = 4'b0000;
      check("fix_out_valid", 32'(out_valid), 1);
      check("fix_beat_cnt", 32'(beat_cnt), 1);
      // Fixed select pointing at an idle channel grants nothing
      sel      = 2'd1;
      in_valid = 4'b1101;
      #1;
      check("fix_idle_sel", 32'(in_ready), 0);
      in_valid = 4'b0000;
      step();

      // Round-robin fairness, pointer starts at 0
      mode     = 1'b1;
      in_data  = {8'hC3, 8'hC2, 8'hC1, 8'hC0};
      in_valid = 4'b1111;
      for (int i = 0; i < 8; i++) expect_beat(2'(i % 4), 8'(8'hC0 + (i % 4)));
      repeat (8) step();
      in_valid = 4'b0000;
      check("rr_beat_cnt", 32'(beat_cnt), 9);
      step();

      // Backpressure: beat on ch0, pointer moves to 1
      in_data   = {8'h00, 8'h00, 8'h00, 8'h30};
      in_valid  = 4'b0001;
      out_ready = 1'b0;
      expect_beat(2'd0, 8'h30);
      step();
      in_valid = 4'b1111;
      for (int i = 0; i < 5; i++) begin
         in_data = {4{8'(8'h80 + i)}};
         #1;
         check("bp_in_ready", 32'(in_ready), 0);
         check("bp_out_data", 32'(out_data), 32'h30);
         check("bp_out_ch", 32'(out_ch), 0);
         step();
      end
      check("bp_out_valid", 32'(out_valid), 1);
      out_ready = 1'b1;
      in_valid  = 4'b0010;
      in_data   = {8'h00, 8'h00, 8'h41, 8'h00};
      #1;
      check("bp_release_ready", 32'(in_ready), 32'b0010);
      expect_beat(2'd1, 8'h41);
      step();
      in_valid = 4'b0000;
      check("bp_reload_valid", 32'(out_valid), 1);
      check("bp_reload_data", 32'(out_data), 32'h41);
      step();

      // Wrap/skip: ch2 moves pointer to 3, then 4'b0011 grants 0 then 1
      in_data  = {8'h00, 8'h52, 8'h61, 8'h60};
      in_valid = 4'b0100;
      expect_beat(2'd2, 8'h52);
      step();
      in_valid = 4'b0011;
      #1;
      check("wrap_ready_0", 32'(in_ready), 32'b0001);
      expect_beat(2'd0, 8'h60);
      step();
      check("wrap_ready_1", 32'(in_ready), 32'b0010);
      expect_beat(2'd1, 8'h61);
      step();
      in_valid = 4'b0000;
      step();
      step();

      // Out-of-range fixed select on the 3-channel instance never grants
      for (int i = 0; i < 3; i++) begin
         check("sel3_in_ready", 32'(in_ready3), 0);
         check("sel3_out_valid", 32'(out_valid3), 0);
         step();
      end

      // Reset while a beat is held
      in_data   = {8'h00, 8'h77, 8'h00, 8'h00};
      in_valid  = 4'b0100;
      out_ready = 1'b0;
      step();
      in_valid = 4'b1111;
      check("mid_held", 32'(out_valid), 1);
      rst_n = 1'b0;
      #1;
      check("mid_out_valid", 32'(out_valid), 0);
      check("mid_beat_cnt", 32'(beat_cnt), 0);
      check("mid_in_ready", 32'(in_ready), 0);
      step();
      rst_n     = 1'b1;
      out_ready = 1'b1;
      in_data   = {8'hD3, 8'hD2, 8'hD1, 8'hD0};
      #1;
      check("mid_restart_ready", 32'(in_ready), 32'b0001);
      expect_beat(2'd0, 8'hD0);
      step();
      in_valid = 4'b0000;
      step();
      step();
      check("queue_empty", 32'(exp_q.size()), 0);

      // Counter wrap
      mon_en   = 1'b0;
      rst_n    = 1'b0;
      mode     = 1'b0;
      sel      = 2'd0;
      in_valid = 4'b0001;
      step();
      rst_n = 1'b1;
      repeat (65535) step();
      check("cnt_ffff", 32'(beat_cnt), 32'hFFFF);
      step();
      check("cnt_wrap", 32'(beat_cnt), 0);
      in_valid = 4'b0000;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
